// File: rtl/rvc_asap_mem_arb.sv
// rvc_asap_mem_arb
//   Shares the single data-side memory bus (D_MEM, CR, VGA) between the core
//   and an external host (loader/debug). One access is granted per cycle,
//   combinationally, in the same cycle as the request. The region is decoded
//   from Addr[MSB_REGION:LSB_REGION] and drives a one-hot Mem_Sel. Read data
//   returns one cycle later to the owner of the access.
//
//   Handshake: a requester raises *_Req and holds its address, data and
//   control fields stable until it sees *_Gnt high in the same cycle. A cycle
//   with Req=1 and Gnt=1 is a completed transfer. Req may be withdrawn
//   without a grant. Read responses (RdValid/Err) are 1-cycle pulses with no
//   back-pressure.
//
//   Arbitration: round-robin between the two requesters. The external host
//   can lock the bus (Ext_Lock sampled with Ext_Gnt). While locked only ext
//   is eligible. If the lock sits idle too long it is dropped and
//   Lock_Timeout pulses.
//
// Ports
//   Clock, Rst_N                     clock, async active-low reset
//   Core_* / Ext_*                   requester side (Req, Addr, WrEn, ByteEn,
//                                    WrData in; Gnt, RdValid, RdData, Err out)
//   Ext_Lock                         keep bus for ext after this access
//   Mem_Addr/RdEn/WrEn/ByteEn/WrData granted access toward memory
//   Mem_Sel                          one-hot {VGA,CR,D}
//   Mem_RdData_D/Cr/Vga              per-region read data (cycle after RdEn)
//   Lock_Timeout                     pulse when the lock is forcibly dropped
module rvc_asap_mem_arb #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LSB_REGION   = 12,
    parameter int MSB_REGION   = 13,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                Clock,
    input  logic                Rst_N,
    input  logic                Core_Req,
    input  logic [ADDR_W-1:0]   Core_Addr,
    input  logic                Core_WrEn,
    input  logic [DATA_W/8-1:0] Core_ByteEn,
    input  logic [DATA_W-1:0]   Core_WrData,
    output logic                Core_Gnt,
    output logic                Core_RdValid,
    output logic [DATA_W-1:0]   Core_RdData,
    output logic                Core_Err,
    input  logic                Ext_Req,
    input  logic [ADDR_W-1:0]   Ext_Addr,
    input  logic                Ext_WrEn,
    input  logic [DATA_W/8-1:0] Ext_ByteEn,
    input  logic [DATA_W-1:0]   Ext_WrData,
    input  logic                Ext_Lock,
    output logic                Ext_Gnt,
    output logic                Ext_RdValid,
    output logic [DATA_W-1:0]   Ext_RdData,
    output logic                Ext_Err,
    output logic [ADDR_W-1:0]   Mem_Addr,
    output logic                Mem_RdEn,
    output logic                Mem_WrEn,
    output logic [DATA_W/8-1:0] Mem_ByteEn,
    output logic [DATA_W-1:0]   Mem_WrData,
    output logic [2:0]          Mem_Sel,
    input  logic [DATA_W-1:0]   Mem_RdData_D,
    input  logic [DATA_W-1:0]   Mem_RdData_Cr,
    input  logic [DATA_W-1:0]   Mem_RdData_Vga,
    output logic                Lock_Timeout
);

    localparam int BE_W  = DATA_W / 8;
    localparam int REG_W = MSB_REGION - LSB_REGION + 1;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_EXT  = 1'b1;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_D    = 3'b001;
    localparam logic [2:0] SEL_CR   = 3'b010;
    localparam logic [2:0] SEL_VGA  = 3'b100;

    // State
    logic             lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_owner_q, last_owner_d;

    // Response pipe: one entry describing last cycle's granted access
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_owner_q, rsp_owner_d;
    logic [2:0] rsp_sel_q, rsp_sel_d;
    logic       rsp_read_q, rsp_read_d;
    logic       rsp_illegal_q, rsp_illegal_d;

    // Arbitration
    logic core_elig, ext_elig;
    logic core_win, ext_win, any_gnt;

    assign core_elig = Core_Req & ~lock_q;
    assign ext_elig  = Ext_Req;

    // Grants are masked while reset is asserted so every output reads 0.
    always_comb begin
        core_win = 1'b0;
        ext_win  = 1'b0;
        if (Rst_N) begin
            if (core_elig && ext_elig) begin
                // Tie goes to whoever did not own the bus last.
                if (last_owner_q == OWNER_EXT) core_win = 1'b1;
                else                           ext_win  = 1'b1;
            end else if (core_elig) begin
                core_win = 1'b1;
            end else if (ext_elig) begin
                ext_win = 1'b1;
            end
        end
    end

    assign any_gnt  = core_win | ext_win;
    assign Core_Gnt = core_win;
    assign Ext_Gnt  = ext_win;

    // Winner mux and region decode
    logic [ADDR_W-1:0] win_addr;
    logic              win_wr;
    logic [BE_W-1:0]   win_be;
    logic [DATA_W-1:0] win_wdata;
    logic [REG_W-1:0]  region;
    logic [2:0]        sel;
    logic              legal;

    always_comb begin
        win_addr  = '0;
        win_wr    = 1'b0;
        win_be    = '0;
        win_wdata = '0;
        if (core_win) begin
            win_addr  = Core_Addr;
            win_wr    = Core_WrEn;
            win_be    = Core_ByteEn;
            win_wdata = Core_WrData;
        end else if (ext_win) begin
            win_addr  = Ext_Addr;
            win_wr    = Ext_WrEn;
            win_be    = Ext_ByteEn;
            win_wdata = Ext_WrData;
        end
    end

    assign region = win_addr[MSB_REGION:LSB_REGION];

    // Region 0 is the instruction memory: not reachable from the data bus,
    // so such an access is still granted but answered with an error.
    always_comb begin
        sel = SEL_NONE;
        if (any_gnt) begin
            if (region == REG_W'(1))      sel = SEL_D;
            else if (region == REG_W'(2)) sel = SEL_CR;
            else if (region == REG_W'(3)) sel = SEL_VGA;
        end
    end

    assign legal      = (sel != SEL_NONE);
    assign Mem_Addr   = win_addr;
    assign Mem_Sel    = sel;
    assign Mem_RdEn   = legal & ~win_wr;
    assign Mem_WrEn   = legal & win_wr;
    assign Mem_ByteEn = (legal && win_wr) ? win_be : '0;
    assign Mem_WrData = (legal && win_wr) ? win_wdata : '0;

    // Lock and timeout
    logic timeout_hit;

    assign timeout_hit  = lock_q & ~ext_win & (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
    assign Lock_Timeout = timeout_hit;

    always_comb begin
        lock_d = lock_q;
        cnt_d  = cnt_q;
        if (ext_win) begin
            lock_d = Ext_Lock;
            cnt_d  = '0;
        end else if (lock_q) begin
            if (timeout_hit) begin
                lock_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (core_win)     last_owner_d = OWNER_CORE;
        else if (ext_win) last_owner_d = OWNER_EXT;
    end

    assign rsp_valid_d   = any_gnt;
    assign rsp_owner_d   = ext_win;
    assign rsp_sel_d     = sel;
    assign rsp_read_d    = ~win_wr;
    assign rsp_illegal_d = any_gnt & ~legal;

    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) begin
            lock_q        <= 1'b0;
            cnt_q         <= '0;
            last_owner_q  <= OWNER_EXT;
            rsp_valid_q   <= 1'b0;
            rsp_owner_q   <= OWNER_CORE;
            rsp_sel_q     <= SEL_NONE;
            rsp_read_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            lock_q        <= lock_d;
            cnt_q         <= cnt_d;
            last_owner_q  <= last_owner_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_owner_q   <= rsp_owner_d;
            rsp_sel_q     <= rsp_sel_d;
            rsp_read_q    <= rsp_read_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    // Response side
    logic              rsp_rd;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;

    assign rsp_rd  = rsp_valid_q & rsp_read_q;
    assign rsp_err = rsp_valid_q & rsp_illegal_q;

    // rsp_sel_q is one-hot (or zero for illegal), so an AND-OR mux suffices
    // and an illegal read naturally returns 0.
    assign rsp_data = ({DATA_W{rsp_rd & rsp_sel_q[0]}} & Mem_RdData_D)
                    | ({DATA_W{rsp_rd & rsp_sel_q[1]}} & Mem_RdData_Cr)
                    | ({DATA_W{rsp_rd & rsp_sel_q[2]}} & Mem_RdData_Vga);

    assign Core_RdValid = rsp_rd & (rsp_owner_q == OWNER_CORE);
    assign Core_Err     = rsp_err & (rsp_owner_q == OWNER_CORE);
    assign Core_RdData  = (rsp_owner_q == OWNER_CORE) ? rsp_data : '0;
    assign Ext_RdValid  = rsp_rd & (rsp_owner_q == OWNER_EXT);
    assign Ext_Err      = rsp_err & (rsp_owner_q == OWNER_EXT);
    assign Ext_RdData   = (rsp_owner_q == OWNER_EXT) ? rsp_data : '0;

`ifndef SYNTHESIS
    // A waiting requester must not change its fields before it is granted.
    core_hold_a: assert property (@(posedge Clock) disable iff (!Rst_N)
        (Core_Req && !Core_Gnt) |=>
        (!Core_Req || $stable({Core_Addr, Core_WrEn, Core_ByteEn, Core_WrData})));
    ext_hold_a: assert property (@(posedge Clock) disable iff (!Rst_N)
        (Ext_Req && !Ext_Gnt) |=>
        (!Ext_Req || $stable({Ext_Addr, Ext_WrEn, Ext_ByteEn, Ext_WrData, Ext_Lock})));
    one_gnt_a: assert property (@(posedge Clock) !(Core_Gnt && Ext_Gnt));
`endif

endmodule

// File: tb/tb_rvc_asap_mem_arb.sv
// Bench for rvc_asap_mem_arb. Inputs are driven on the falling edge,
// combinational grant/bus outputs are sampled 2 ns later, and registered
// responses are sampled 3 ns after the rising edge by a monitor that pops the
// expected response queue.
module tb_rvc_asap_mem_arb;

    localparam logic [31:0] D_VAL   = 32'hDEADBEEF;
    localparam logic [31:0] CR_VAL  = 32'hC0FFEE01;
    localparam logic [31:0] VGA_VAL = 32'h0BADF00D;

    logic        clk;
    logic        Rst_N;
    logic        Core_Req, Core_WrEn, Core_Gnt, Core_RdValid, Core_Err;
    logic [31:0] Core_Addr, Core_WrData, Core_RdData;
    logic [3:0]  Core_ByteEn;
    logic        Ext_Req, Ext_WrEn, Ext_Lock, Ext_Gnt, Ext_RdValid, Ext_Err;
    logic [31:0] Ext_Addr, Ext_WrData, Ext_RdData;
    logic [3:0]  Ext_ByteEn;
    logic [31:0] Mem_Addr, Mem_WrData;
    logic        Mem_RdEn, Mem_WrEn, Lock_Timeout;
    logic [3:0]  Mem_ByteEn;
    logic [2:0]  Mem_Sel;
    logic [31:0] Mem_RdData_D, Mem_RdData_Cr, Mem_RdData_Vga;

    int n_chk  = 0;
    int n_pass = 0;
    logic [67:0] exp_q[$];
    logic [143:0] all_out;

    rvc_asap_mem_arb dut (
        .Clock(clk), .Rst_N(Rst_N),
        .Core_Req(Core_Req), .Core_Addr(Core_Addr), .Core_WrEn(Core_WrEn),
        .Core_ByteEn(Core_ByteEn), .Core_WrData(Core_WrData), .Core_Gnt(Core_Gnt),
        .Core_RdValid(Core_RdValid), .Core_RdData(Core_RdData), .Core_Err(Core_Err),
        .Ext_Req(Ext_Req), .Ext_Addr(Ext_Addr), .Ext_WrEn(Ext_WrEn),
        .Ext_ByteEn(Ext_ByteEn), .Ext_WrData(Ext_WrData), .Ext_Lock(Ext_Lock),
        .Ext_Gnt(Ext_Gnt), .Ext_RdValid(Ext_RdValid), .Ext_RdData(Ext_RdData),
        .Ext_Err(Ext_Err),
        .Mem_Addr(Mem_Addr), .Mem_RdEn(Mem_RdEn), .Mem_WrEn(Mem_WrEn),
        .Mem_ByteEn(Mem_ByteEn), .Mem_WrData(Mem_WrData), .Mem_Sel(Mem_Sel),
        .Mem_RdData_D(Mem_RdData_D), .Mem_RdData_Cr(Mem_RdData_Cr),
        .Mem_RdData_Vga(Mem_RdData_Vga), .Lock_Timeout(Lock_Timeout)
    );

    assign all_out = {Core_Gnt, Ext_Gnt, Core_RdValid, Core_Err, Core_RdData,
                      Ext_RdValid, Ext_Err, Ext_RdData, Mem_Addr, Mem_RdEn,
                      Mem_WrEn, Mem_ByteEn, Mem_WrData, Mem_Sel, Lock_Timeout};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected response {rd_valid, err, data} for a granted access
    function automatic logic [33:0] resp_of(input logic [31:0] a, input logic rd);
        logic [1:0] r;
        r = a[13:12];
        if (r == 2'b00) return {rd, 1'b1, 32'h0};
        if (!rd) return 34'h0;
        case (r)
            2'b01:   return {2'b10, D_VAL};
            2'b10:   return {2'b10, CR_VAL};
            default: return {2'b10, VGA_VAL};
        endcase
    endfunction

    function automatic logic [2:0] sel_of(input logic [31:0] a);
        case (a[13:12])
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Scoreboard monitor: every cycle compares the registered responses
    // against the entry pushed when the access was granted (0 if none).
    always @(posedge clk) begin
        logic [67:0] act, xp;
        #3;
        act = {Core_RdValid, Core_Err, Core_RdData, Ext_RdValid, Ext_Err, Ext_RdData};
        xp  = (exp_q.size() > 0) ? exp_q.pop_front() : 68'h0;
        n_chk++;
        if (act !== xp)
            $display("FAIL resp t=%0t got %h want %h", $time, act, xp);
        else
            n_pass++;
    end

    // Driver: one bus cycle with expected grants / timeout
    task automatic cycle(input logic cr, input logic [31:0] ca, input logic cw,
                         input logic er, input logic [31:0] ea, input logic ew,
                         input logic el, input logic xcg, input logic xeg,
                         input logic xto);
        logic [31:0] wa, wd;
        logic        ww, g;
        logic [3:0]  wbe;
        logic [2:0]  xsel;
        @(negedge clk);
        Core_Req = cr; Core_Addr = ca; Core_WrEn = cw;
        Core_ByteEn = 4'hF; Core_WrData = ca ^ 32'h5A5A_0000;
        Ext_Req = er; Ext_Addr = ea; Ext_WrEn = ew; Ext_Lock = el;
        Ext_ByteEn = 4'h3; Ext_WrData = ea ^ 32'h0000_A5A5;
        #2;
        g    = xcg | xeg;
        wa   = xcg ? ca : (xeg ? ea : 32'h0);
        ww   = xcg ? cw : (xeg ? ew : 1'b0);
        wbe  = xcg ? 4'hF : 4'h3;
        wd   = xcg ? (ca ^ 32'h5A5A_0000) : (ea ^ 32'h0000_A5A5);
        xsel = g ? sel_of(wa) : 3'b000;

        n_chk++; if (Core_Gnt !== xcg) $display("FAIL core_gnt t=%0t got %b want %b", $time, Core_Gnt, xcg); else n_pass++;
        n_chk++; if (Ext_Gnt !== xeg) $display("FAIL ext_gnt t=%0t got %b want %b", $time, Ext_Gnt, xeg); else n_pass++;
        n_chk++; if (Lock_Timeout !== xto) $display("FAIL lock_timeout t=%0t got %b want %b", $time, Lock_Timeout, xto); else n_pass++;
        n_chk++; if (Mem_Addr !== wa) $display("FAIL mem_addr t=%0t got %h want %h", $time, Mem_Addr, wa); else n_pass++;
        n_chk++; if (Mem_Sel !== xsel) $display("FAIL mem_sel t=%0t got %b want %b", $time, Mem_Sel, xsel); else n_pass++;
        n_chk++; if (Mem_RdEn !== (xsel != 0 && !ww)) $display("FAIL mem_rden t=%0t got %b", $time, Mem_RdEn); else n_pass++;
        n_chk++; if (Mem_WrEn !== (xsel != 0 && ww)) $display("FAIL mem_wren t=%0t got %b", $time, Mem_WrEn); else n_pass++;
        if (xsel != 0 && ww) begin
            n_chk++;
            if ({Mem_ByteEn, Mem_WrData} !== {wbe, wd})
                $display("FAIL mem_wdata t=%0t got %h/%h want %h/%h", $time, Mem_ByteEn, Mem_WrData, wbe, wd);
            else n_pass++;
        end else if (g && !ww) begin
            n_chk++;
            if (Mem_ByteEn !== 4'h0) $display("FAIL mem_be_read t=%0t got %h want 0", $time, Mem_ByteEn);
            else n_pass++;
        end
        exp_q.push_back({xcg ? resp_of(ca, !cw) : 34'h0, xeg ? resp_of(ea, !ew) : 34'h0});
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic zero_inputs();
        Core_Req = 0; Core_Addr = 0; Core_WrEn = 0; Core_ByteEn = 0; Core_WrData = 0;
        Ext_Req = 0; Ext_Addr = 0; Ext_WrEn = 0; Ext_ByteEn = 0; Ext_WrData = 0; Ext_Lock = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        Rst_N = 1'b0;
        zero_inputs();
        exp_q.delete();
        repeat (2) @(negedge clk);
        Rst_N = 1'b1;
    endtask

    // Tests
    task automatic test_reset();
        Rst_N = 1'b0;
        zero_inputs();
        Core_Req = 1'b1; Core_Addr = 32'h1000; Ext_Req = 1'b1; Ext_Addr = 32'h2000;
        repeat (2) @(negedge clk);
        #2;
        n_chk++; if (all_out !== '0) $display("FAIL reset_outputs got %h want 0", all_out); else n_pass++;
        @(negedge clk);
        zero_inputs();
        Rst_N = 1'b1;
    endtask

    task automatic test_core_read();
        cycle(1, 32'h1004, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        cycle(1, 32'h2010, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        cycle(1, 32'h3020, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        cycle(1, 32'h1040, 1, 0, 32'h0, 0, 0, 1, 0, 0);
        idle();
    endtask

    task automatic test_illegal();
        cycle(1, 32'h0010, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        cycle(0, 32'h0, 0, 1, 32'h0020, 1, 0, 0, 1, 0);
        cycle(0, 32'h0, 0, 1, 32'h0024, 0, 0, 0, 1, 0);
        idle();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 6; i++)
            cycle(1, 32'h1004, 0, 1, 32'h2008, 0, 0, (i % 2) == 0, (i % 2) == 1, 0);
        idle();
    endtask

    task automatic test_lock();
        cycle(1, 32'h1000, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        cycle(1, 32'h1000, 0, 1, 32'h3000, 1, 1, 0, 1, 0);
        cycle(1, 32'h1000, 0, 1, 32'h3004, 1, 1, 0, 1, 0);
        cycle(1, 32'h1000, 0, 1, 32'h3008, 1, 0, 0, 1, 0);
        cycle(1, 32'h1000, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        idle();
    endtask

    task automatic test_timeout();
        cycle(0, 32'h0, 0, 1, 32'h2000, 1, 1, 0, 1, 0);
        for (int i = 1; i <= 16; i++)
            cycle(1, 32'h1008, 0, 0, 32'h0, 0, 0, 0, 0, i == 16);
        cycle(1, 32'h1008, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        idle();
    endtask

    task automatic test_reset_mid_op();
        cycle(1, 32'h2018, 0, 0, 32'h0, 0, 0, 1, 0, 0);
        @(negedge clk);
        Rst_N = 1'b0;
        Ext_Req = 1'b1; Ext_Addr = 32'h1000; Ext_WrEn = 1'b0;
        #2;
        n_chk++; if (all_out !== '0) $display("FAIL reset_mid_1 got %h want 0", all_out); else n_pass++;
        @(negedge clk);
        #2;
        n_chk++; if (all_out !== '0) $display("FAIL reset_mid_2 got %h want 0", all_out); else n_pass++;
        @(negedge clk);
        zero_inputs();
        Rst_N = 1'b1;
        cycle(1, 32'h2018, 0, 1, 32'h1000, 0, 0, 1, 0, 0);
        cycle(1, 32'h2018, 0, 1, 32'h1000, 0, 0, 0, 1, 0);
        idle();
    endtask

    // Random round-robin traffic; denied requests are held unchanged.
    task automatic test_random();
        logic        cr, cw, er, ew, xcg, xeg, last;
        logic [31:0] ca, ea;
        logic        c_pend, e_pend;
        apply_reset();
        last = 1'b1;
        c_pend = 0; e_pend = 0;
        cr = 0; cw = 0; er = 0; ew = 0; ca = 0; ea = 0;
        for (int i = 0; i < 40; i++) begin
            if (!c_pend) begin
                cr = 1'($urandom_range(0, 1));
                cw = 1'($urandom_range(0, 1));
                ca = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 255)) << 2);
            end
            if (!e_pend) begin
                er = 1'($urandom_range(0, 1));
                ew = 1'($urandom_range(0, 1));
                ea = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 255)) << 2);
            end
            if (cr && er) begin
                xcg = last;
                xeg = !last;
            end else begin
                xcg = cr;
                xeg = er;
            end
            cycle(cr, ca, cw, er, ea, ew, 0, xcg, xeg, 0);
            c_pend = cr && !xcg;
            e_pend = er && !xeg;
            if (xcg) last = 1'b0;
            if (xeg) last = 1'b1;
        end
        idle();
    endtask

    initial begin
        Mem_RdData_D   = D_VAL;
        Mem_RdData_Cr  = CR_VAL;
        Mem_RdData_Vga = VGA_VAL;
        test_reset();
        test_core_read();
        test_illegal();
        test_back_to_back();
        test_lock();
        test_timeout();
        test_reset_mid_op();
        test_random();
        idle();
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
